count_sequencer: RTL and testbench

Command-driven controller that sequences a WIDTH-bit counter register built from async-reset D flip-flops.
Accepts load, limit, start, stop and clear commands over a valid/ready interface. Runs the register up or down, one step per qualified tick. Supports one-shot or auto-reload operation.
Reports terminal count, busy and done status to the surrounding timer/counter subsystem.

---
 rtl/count_sequencer_pkg.sv | 29 ++
 rtl/count_sequencer_count_reg.sv | 22 ++
 rtl/count_sequencer.sv | 177 +++++++++++++++++
 tb/tb_count_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/count_sequencer_pkg.sv
// Shared types for the count sequencer: command opcodes, FSM states and
// a small state-decode helper.
package count_sequencer_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP        = 3'd0,
        OP_LOAD       = 3'd1,
        OP_SET_LIMIT  = 3'd2,
        OP_START_UP   = 3'd3,
        OP_START_DOWN = 3'd4,
        OP_STOP       = 3'd5,
        OP_CLEAR      = 3'd6,
        OP_RSVD       = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN_UP   = 2'd1,
        ST_RUN_DOWN = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    function automatic logic is_run(input state_e st);
        return (st == ST_RUN_UP) || (st == ST_RUN_DOWN);
    endfunction

endpackage

// File: rtl/count_sequencer_count_reg.sv
// WIDTH-bit counter storage: async active-low reset to zero, loads
// load_data when load_en is high, otherwise holds.
module count_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q
);

    // Counter storage flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= {WIDTH{1'b0}};
        end else if (load_en) begin
            q <= load_data;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven up/down counter sequencer with one-shot or auto-reload
// operation, terminal-count pulse and busy/done status.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_auto,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] limit,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_next_s;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH-1:0] limit_next_s;
    logic             auto_r;
    logic             auto_next_s;
    logic             ready_r;
    logic             tc_r;
    logic             tc_next_s;
    logic             busy_r;
    logic             busy_next_s;
    logic             done_r;
    logic             done_next_s;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] count_next_s;
    logic             count_en_s;
    op_e              op_s;
    logic             accept_s;
    logic             step_s;
    logic             at_term_s;

    assign op_s     = op_e'(cmd_op);
    assign accept_s = cmd_valid & ready_r;
    // An accepted command takes priority over a tick in the same cycle.
    assign step_s   = en_tick & ~accept_s & is_run(state_r);

    count_reg #(
        .WIDTH     (WIDTH)
    ) u_count_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_en   (count_en_s),
        .load_data (count_next_s),
        .q         (count_s)
    );

    // Terminal value depends on direction: limit going up, zero going down.
    always_comb begin
        at_term_s = 1'b0;
        if (state_r == ST_RUN_UP) begin
            at_term_s = (count_s == limit_r);
        end else begin
            at_term_s = (count_s == ZERO);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        if (accept_s) begin
            case (op_s)
                OP_START_UP:       state_next_s = ST_RUN_UP;
                OP_START_DOWN:     state_next_s = ST_RUN_DOWN;
                OP_STOP, OP_CLEAR: state_next_s = ST_IDLE;
                default:           state_next_s = state_r;
            endcase
        end else if (step_s && at_term_s && !auto_r) begin
            state_next_s = ST_DONE;
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM output decode, registered so busy/done follow the state register.
    always_comb begin
        busy_next_s = is_run(state_next_s);
        done_next_s = (state_next_s == ST_DONE);
    end

    // Datapath: counter next value, limit, auto flag and terminal pulse.
    always_comb begin
        count_en_s   = 1'b0;
        count_next_s = count_s;
        limit_next_s = limit_r;
        auto_next_s  = auto_r;
        tc_next_s    = 1'b0;
        if (accept_s) begin
            case (op_s)
                OP_LOAD: begin
                    count_en_s   = 1'b1;
                    count_next_s = cmd_data;
                end
                OP_SET_LIMIT: begin
                    limit_next_s = cmd_data;
                end
                OP_START_UP, OP_START_DOWN: begin
                    auto_next_s = cmd_auto;
                end
                OP_CLEAR: begin
                    count_en_s   = 1'b1;
                    count_next_s = ZERO;
                end
                default: begin
                    count_en_s = 1'b0;
                end
            endcase
        end else if (step_s) begin
            tc_next_s = at_term_s;
            if (at_term_s) begin
                // One-shot holds the terminal value; auto-reload restarts.
                if (auto_r) begin
                    count_en_s   = 1'b1;
                    count_next_s = (state_r == ST_RUN_UP) ? ZERO : limit_r;
                end else begin
                    count_en_s = 1'b0;
                end
            end else begin
                count_en_s   = 1'b1;
                count_next_s = (state_r == ST_RUN_UP) ? (count_s + ONE) : (count_s - ONE);
            end
        end else begin
            tc_next_s = 1'b0;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            limit_r <= LIMIT_RST;
            auto_r  <= 1'b0;
            ready_r <= 1'b0;
            tc_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            limit_r <= limit_next_s;
            auto_r  <= auto_next_s;
            ready_r <= ~accept_s;
            tc_r    <= tc_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    assign cmd_ready = ready_r;
    assign count     = count_s;
    assign limit     = limit_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign tc        = tc_r;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: stimulus queues hand-computed
// per-cycle snapshots, a negedge monitor pops and compares them.
module tb_count_sequencer;
    import count_sequencer_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       en_tick;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_auto;
    logic [7:0] count;
    logic [7:0] limit;
    logic       busy;
    logic       done;
    logic       tc;

    typedef struct {
        int         at;
        string      name;
        logic [7:0] cnt;
        logic [7:0] lim;
        logic       b;
        logic       d;
        logic       t;
        logic       r;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    count_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_tick   (en_tick),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_auto  (cmd_auto),
        .count     (count),
        .limit     (limit),
        .busy      (busy),
        .done      (done),
        .tc        (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued snapshot due in this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.at < cyc) begin
                errors++;
                $display("FAIL %s missed: due cycle %0d, now %0d", e.name, e.at, cyc);
            end else if ({count, limit, busy, done, tc, cmd_ready} !==
                         {e.cnt, e.lim, e.b, e.d, e.t, e.r}) begin
                errors++;
                $display("FAIL %s cyc=%0d actual cnt=%h lim=%h busy=%b done=%b tc=%b rdy=%b required cnt=%h lim=%h busy=%b done=%b tc=%b rdy=%b",
                         e.name, cyc, count, limit, busy, done, tc, cmd_ready,
                         e.cnt, e.lim, e.b, e.d, e.t, e.r);
            end
        end
    end

    task automatic exp_k(input int k, input string nm, input logic [7:0] c, input logic [7:0] l,
                         input logic b, input logic d, input logic t, input logic r);
        exp_t x;
        x.at = cyc + k; x.name = nm; x.cnt = c; x.lim = l;
        x.b = b; x.d = d; x.t = t; x.r = r;
        exp_q.push_back(x);
    endtask

    task automatic drv(input logic v, input op_e op, input logic [7:0] dat, input logic au, input logic tk);
        @(posedge clk);
        #1;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = dat;
        cmd_auto  = au;
        en_tick   = tk;
    endtask

    task automatic cmd(input op_e op, input logic [7:0] dat, input logic au, input logic tk);
        drv(1'b1, op, dat, au, tk);
    endtask

    task automatic idle(input logic tk);
        drv(1'b0, OP_NOP, 8'h00, 1'b0, tk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'h00;
        cmd_auto  = 1'b0;
        en_tick   = 1'b0;

        // Power-on reset and first ready.
        @(posedge clk); #1;
        exp_k(0, "reset", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        exp_k(0, "ready_after_reset", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);

        // One-shot up to limit 5.
        cmd(OP_SET_LIMIT, 8'h05, 1'b0, 1'b0); exp_k(1, "set_limit5", 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);                           exp_k(1, "ready_back", 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1);
        cmd(OP_CLEAR, 8'h00, 1'b0, 1'b0);     exp_k(1, "clear",      8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cmd(OP_START_UP, 8'h00, 1'b0, 1'b0);  exp_k(1, "start_up",   8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            idle(1'b1); exp_k(1, "up_step", 8'(i), 8'h05, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        idle(1'b1); exp_k(1, "up_tc",        8'h05, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b1); exp_k(1, "done_ignore1", 8'h05, 8'h05, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "done_ignore2", 8'h05, 8'h05, 1'b0, 1'b1, 1'b0, 1'b1);

        // Auto-reload down with limit 7.
        cmd(OP_SET_LIMIT, 8'h07, 1'b0, 1'b0);  exp_k(1, "set_limit7", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        cmd(OP_LOAD, 8'h03, 1'b0, 1'b0);       exp_k(1, "load3",      8'h03, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        cmd(OP_START_DOWN, 8'h00, 1'b1, 1'b0); exp_k(1, "start_down", 8'h03, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1); exp_k(1, "down2",   8'h02, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "down1",   8'h01, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "down0",   8'h00, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "reload7", 8'h07, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b1); exp_k(1, "down6",   8'h06, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "down5",   8'h05, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1);

        // Collision: STOP with en_tick in the same cycle.
        cmd(OP_LOAD, 8'h04, 1'b0, 1'b0);     exp_k(1, "load4_running", 8'h04, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cmd(OP_START_UP, 8'h00, 1'b0, 1'b0); exp_k(1, "start_up4",     8'h04, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cmd(OP_STOP, 8'h00, 1'b0, 1'b1);     exp_k(1, "stop_collide",  8'h04, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);                          exp_k(1, "idle_ignore",   8'h04, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back: valid held, second command waits for ready.
        cmd(OP_LOAD, 8'h10, 1'b0, 1'b0);      exp_k(1, "b2b_load",    8'h10, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        cmd(OP_SET_LIMIT, 8'h20, 1'b0, 1'b0); exp_k(1, "b2b_blocked", 8'h10, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
        cmd(OP_SET_LIMIT, 8'h20, 1'b0, 1'b0); exp_k(1, "b2b_limit",   8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);                           exp_k(1, "b2b_final",   8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);

        // Wrap through 0xFF -> 0x00 on the way up to limit 2.
        cmd(OP_SET_LIMIT, 8'h02, 1'b0, 1'b0); exp_k(1, "set_limit2", 8'h10, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cmd(OP_LOAD, 8'hFE, 1'b0, 1'b0);      exp_k(1, "loadFE",     8'hFE, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cmd(OP_START_UP, 8'h00, 1'b0, 1'b0);  exp_k(1, "start_wrap", 8'hFE, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1); exp_k(1, "wrapFF", 8'hFF, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "wrap00", 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "wrap01", 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "wrap02", 8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "wrap_tc", 8'h02, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b0); exp_k(1, "wrap_tc_end", 8'h02, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1);

        // Restart from DONE counting down from the held value.
        cmd(OP_START_DOWN, 8'h00, 1'b0, 1'b0); exp_k(1, "restart_down", 8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1); exp_k(1, "rd1",   8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "rd0",   8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "rd_tc", 8'h00, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a run.
        cmd(OP_LOAD, 8'h23, 1'b0, 1'b0);     exp_k(1, "load23",   8'h23, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        cmd(OP_START_UP, 8'h00, 1'b0, 1'b0); exp_k(1, "run23",    8'h23, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);                          exp_k(1, "run23_hold", 8'h23, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b0;
        exp_k(0, "midrun_reset", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        #4 reset_n = 1'b1;
        exp_k(1, "post_reset_ready", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1); exp_k(1, "post_reset_idle", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        repeat (4) @(posedge clk);
        #6;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
